// File: rtl/wt_store_coalesce_buf_pkg.sv
// Shared write-through cache definitions: buffer configuration, entry layout
// and the byte-merge helper used by the store coalescing buffer.
package wt_store_coalesce_buf_pkg;

    localparam int unsigned WtDcacheWbufDepth = 8;
    localparam int unsigned CheriCapTagWidth  = 1;
    localparam int unsigned WtAddrWidth       = 64;
    localparam int unsigned WtStoreAgeMax     = WtDcacheWbufDepth / 2;

    // Address and tag fields are sized for the widest configuration; narrower
    // instances use the low bits and leave the rest at zero.
    typedef struct packed {
        logic [WtAddrWidth-1:0]      addr;
        logic [63:0]                 data;
        logic [7:0]                  be;
        logic [CheriCapTagWidth-1:0] tag;
        logic                        nc;
        logic                        valid;
    } wbuf_entry_t;

    typedef enum logic {
        DRAIN_IDLE   = 1'b0,
        DRAIN_ISSUED = 1'b1
    } drain_state_e;

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_data,
                                                input logic [63:0] new_data,
                                                input logic [7:0]  be);
        logic [63:0] res;
        res = old_data;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) res[8*b +: 8] = new_data[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wt_store_coalesce_buf_if.sv
// Store request and memory drain handshakes of the coalescing buffer.
// The slave modport is the buffer side, the master modport the environment side.
interface wt_store_coalesce_buf_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned TAG_W  = 1
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [ADDR_W-1:0] req_addr_i;
    logic [63:0]       req_data_i;
    logic [7:0]        req_be_i;
    logic [TAG_W-1:0]  req_tag_i;
    logic              req_nc_i;

    logic              mem_valid_o;
    logic              mem_ready_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [63:0]       mem_data_o;
    logic [7:0]        mem_be_o;
    logic [TAG_W-1:0]  mem_tag_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_data_i, req_be_i, req_tag_i, req_nc_i,
        output req_ready_o,
        output mem_valid_o, mem_addr_o, mem_data_o, mem_be_o, mem_tag_o,
        input  mem_ready_i
    );

    modport master (
        output req_valid_i, req_addr_i, req_data_i, req_be_i, req_tag_i, req_nc_i,
        input  req_ready_o,
        input  mem_valid_o, mem_addr_o, mem_data_o, mem_be_o, mem_tag_o,
        output mem_ready_i
    );
endinterface

// File: rtl/wt_store_coalesce_cam.sv
// Word-address comparator array: flags whether any valid buffer entry holds
// the same 8-byte word as the lookup key.
module wt_store_coalesce_cam #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned WORD_W = 61
) (
    input  logic [DEPTH-1:0][WORD_W-1:0] words_i,
    input  logic [DEPTH-1:0]             valid_i,
    input  logic [WORD_W-1:0]            key_i,
    output logic                         hit_o
);
    logic [DEPTH-1:0] match;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign match[i] = valid_i[i] && (words_i[i] == key_i);
    end

    assign hit_o = |match;
endmodule

// File: rtl/wt_store_coalesce_buf.sv
// Write-through store buffer: FIFO of 64-bit word stores that merges a new
// store into the youngest entry when it targets the same cacheable word.
module wt_store_coalesce_buf
    import wt_store_coalesce_buf_pkg::*;
#(
    parameter int unsigned DEPTH   = WtDcacheWbufDepth,
    parameter int unsigned ADDR_W  = WtAddrWidth,
    parameter int unsigned TAG_W   = CheriCapTagWidth,
    parameter int unsigned AGE_MAX = WtStoreAgeMax
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    wt_store_coalesce_buf_if.slave bus,
    input  logic                   flush_i,
    input  logic [ADDR_W-1:0]      ld_addr_i,
    output logic                   ld_hit_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned AGE_W  = $clog2(AGE_MAX + 1);
    localparam int unsigned WORD_W = ADDR_W - 3;

    wbuf_entry_t      entries_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, young_idx;
    logic [CNT_W-1:0] count_q, count_d;
    logic [AGE_W-1:0] age_q, age_d;
    drain_state_e     state_q, state_d;

    wbuf_entry_t      alloc_entry, merge_entry;
    logic             issued, merge_ok, accept, do_alloc, do_merge, do_pop;
    logic [TAG_W-1:0] new_tag;
    logic             unused_lsbs;

    logic [DEPTH-1:0][WORD_W-1:0] cam_words;
    logic [DEPTH-1:0]             cam_valid;

    assign young_idx = wr_ptr_q - PTR_W'(1);
    assign issued    = (state_q == DRAIN_ISSUED);
    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign count_o   = count_q;

    // Once the head is on the bus its contents must not change, so a lone
    // issued head is closed to merging.
    assign merge_ok = !empty_o
                   && !entries_q[young_idx].nc
                   && !bus.req_nc_i
                   && (entries_q[young_idx].addr[ADDR_W-1:3] == bus.req_addr_i[ADDR_W-1:3])
                   && !(issued && count_q == CNT_W'(1));

    assign bus.req_ready_o = !rst_i && (!full_o || merge_ok);
    assign accept          = bus.req_valid_i && bus.req_ready_o;
    assign do_merge        = accept && merge_ok;
    assign do_alloc        = accept && !merge_ok;
    assign do_pop          = issued && bus.mem_ready_i;
    assign new_tag         = (bus.req_be_i == 8'hFF) ? bus.req_tag_i : '0;

    always_comb begin
        alloc_entry                    = '0;
        alloc_entry.addr[ADDR_W-1:3]   = bus.req_addr_i[ADDR_W-1:3];
        alloc_entry.data               = bus.req_data_i;
        alloc_entry.be                 = bus.req_be_i;
        alloc_entry.tag[TAG_W-1:0]     = new_tag;
        alloc_entry.nc                 = bus.req_nc_i;
        alloc_entry.valid              = 1'b1;

        merge_entry                    = entries_q[young_idx];
        merge_entry.data               = merge_bytes(entries_q[young_idx].data,
                                                     bus.req_data_i, bus.req_be_i);
        merge_entry.be                 = entries_q[young_idx].be | bus.req_be_i;
        merge_entry.tag                = '0;
        merge_entry.tag[TAG_W-1:0]     = new_tag;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DRAIN_IDLE: begin
                if (!empty_o && (count_q >= CNT_W'(2) || flush_i
                                 || age_q == AGE_W'(AGE_MAX))) begin
                    state_d = DRAIN_ISSUED;
                end
            end
            DRAIN_ISSUED: begin
                if (bus.mem_ready_i) state_d = DRAIN_IDLE;
            end
            default: state_d = DRAIN_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = do_alloc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        if (do_alloc && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (!do_alloc && do_pop) count_d = count_q - CNT_W'(1);

        age_d = age_q;
        if (do_pop || empty_o) begin
            age_d = '0;
        end else if (count_q == CNT_W'(1)) begin
            if (do_merge)                                   age_d = '0;
            else if (!issued && age_q != AGE_W'(AGE_MAX))   age_d = age_q + AGE_W'(1);
        end
    end

    // NOTE: only the valid bits are reset; payload fields are don't-care
    // while invalid, so they stay plain enable flops without a reset term.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            age_q    <= '0;
            state_q  <= DRAIN_IDLE;
            for (int i = 0; i < DEPTH; i++) entries_q[i].valid <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            age_q    <= age_d;
            state_q  <= state_d;
            if (do_alloc) entries_q[wr_ptr_q]  <= alloc_entry;
            if (do_merge) entries_q[young_idx] <= merge_entry;
            if (do_pop)   entries_q[rd_ptr_q].valid <= 1'b0;
        end
    end

    assign bus.mem_valid_o = issued;
    assign bus.mem_addr_o  = entries_q[rd_ptr_q].addr[ADDR_W-1:0];
    assign bus.mem_data_o  = entries_q[rd_ptr_q].data;
    assign bus.mem_be_o    = entries_q[rd_ptr_q].be;
    assign bus.mem_tag_o   = entries_q[rd_ptr_q].tag[TAG_W-1:0];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cam_words[i] = entries_q[i].addr[ADDR_W-1:3];
            cam_valid[i] = entries_q[i].valid;
        end
    end

    wt_store_coalesce_cam #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_cam (
        .words_i (cam_words),
        .valid_i (cam_valid),
        .key_i   (ld_addr_i[ADDR_W-1:3]),
        .hit_o   (ld_hit_o)
    );

    assign unused_lsbs = ^{bus.req_addr_i[2:0], ld_addr_i[2:0]};
endmodule

// File: tb/tb_wt_store_coalesce_buf.sv
// Bench for wt_store_coalesce_buf: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based reference model.
module tb_wt_store_coalesce_buf;
    import wt_store_coalesce_buf_pkg::*;

    localparam int DEPTH   = 8;
    localparam int AGE_MAX = 4;

    typedef struct {
        logic [60:0] word;
        logic [63:0] data;
        logic [7:0]  be;
        logic        tag;
        logic        nc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [63:0] ld_addr;
    logic        ld_hit, empty, full;
    logic [3:0]  count;

    int   n_vectors;
    int   n_miscompares;
    bit   chk_en;
    ent_t q[$];
    bit   m_issued;
    int   m_age;

    always #5 clk = ~clk;

    wt_store_coalesce_buf_if #(.ADDR_W(64), .TAG_W(1)) bus ();

    wt_store_coalesce_buf #(
        .DEPTH   (DEPTH),
        .ADDR_W  (64),
        .TAG_W   (1),
        .AGE_MAX (AGE_MAX)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .flush_i   (flush),
        .ld_addr_i (ld_addr),
        .ld_hit_o  (ld_hit),
        .empty_o   (empty),
        .full_o    (full),
        .count_o   (count)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vectors++;
        assert (obs === exp) else begin
            n_miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] be_mask(input logic [7:0] be);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{be[b]}};
        return m;
    endfunction

    task automatic set_req(input logic v, input logic [63:0] a, input logic [63:0] d,
                           input logic [7:0] be, input logic tg, input logic nc);
        bus.req_valid_i = v;
        bus.req_addr_i  = a;
        bus.req_data_i  = d;
        bus.req_be_i    = be;
        bus.req_tag_i   = tg;
        bus.req_nc_i    = nc;
    endtask

    task automatic idle();
        set_req(1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b0);
    endtask

    // Compares all outputs against the model, then advances model and DUT by one clock.
    task automatic tick();
        int          n;
        logic [60:0] w;
        logic        m_merge, m_ready, m_hit, m_pop, m_start;
        ent_t        e;
        #1;
        n = q.size();
        w = bus.req_addr_i[63:3];
        m_merge = 1'b0;
        if (n > 0)
            m_merge = !q[n-1].nc && !bus.req_nc_i && (q[n-1].word == w) && !(n == 1 && m_issued);
        m_ready = !rst && (n < DEPTH || m_merge);
        m_hit = 1'b0;
        foreach (q[i]) if (q[i].word == ld_addr[63:3]) m_hit = 1'b1;

        if (chk_en) begin
            check("count", count, n);
            check("empty", empty, n == 0);
            check("full", full, n == DEPTH);
            check("mem_valid", bus.mem_valid_o, m_issued);
            if (m_issued && n > 0) begin
                check("mem_addr", bus.mem_addr_o, {q[0].word, 3'b000});
                check("mem_data", bus.mem_data_o & be_mask(q[0].be), q[0].data & be_mask(q[0].be));
                check("mem_be", bus.mem_be_o, q[0].be);
                check("mem_tag", bus.mem_tag_o, q[0].tag);
            end
            check("req_ready", bus.req_ready_o, m_ready);
            check("ld_hit", ld_hit, m_hit);
        end

        m_pop   = m_issued && bus.mem_ready_i;
        m_start = !m_issued && n > 0 && (n >= 2 || flush || m_age == AGE_MAX);
        if (rst) begin
            q.delete();
            m_issued = 1'b0;
            m_age    = 0;
        end else begin
            if (m_pop || n == 0)                                m_age = 0;
            else if (n == 1 && bus.req_valid_i && m_merge)      m_age = 0;
            else if (n == 1 && !m_issued && m_age < AGE_MAX)    m_age++;

            if (bus.req_valid_i && m_ready) begin
                if (m_merge) begin
                    for (int b = 0; b < 8; b++)
                        if (bus.req_be_i[b]) q[n-1].data[8*b +: 8] = bus.req_data_i[8*b +: 8];
                    q[n-1].be  = q[n-1].be | bus.req_be_i;
                    q[n-1].tag = (bus.req_be_i == 8'hFF) ? bus.req_tag_i : 1'b0;
                end else begin
                    e.word = w;
                    e.data = bus.req_data_i;
                    e.be   = bus.req_be_i;
                    e.tag  = (bus.req_be_i == 8'hFF) ? bus.req_tag_i : 1'b0;
                    e.nc   = bus.req_nc_i;
                    q.push_back(e);
                end
            end
            if (m_pop) void'(q.pop_front());
            if (m_pop)        m_issued = 1'b0;
            else if (m_start) m_issued = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_issue(input string tag);
        for (int k = 0; k < 20; k++) begin
            if (bus.mem_valid_o === 1'b1) break;
            tick();
        end
        check({tag, "_issue"}, bus.mem_valid_o, 1'b1);
    endtask

    task automatic drain_all();
        idle();
        flush           = 1'b1;
        bus.mem_ready_i = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (empty === 1'b1) break;
            tick();
        end
        flush           = 1'b0;
        bus.mem_ready_i = 1'b0;
        check("drain_empty", empty, 1'b1);
    endtask

    initial begin
        int lat;
        int hs;
        n_vectors     = 0;
        n_miscompares = 0;
        chk_en        = 1'b0;
        m_issued      = 1'b0;
        m_age         = 0;
        rst           = 1'b1;
        flush         = 1'b0;
        ld_addr       = 64'h0;
        bus.mem_ready_i = 1'b0;
        idle();

        // Reset: first cycle unchecked, second checks ready held low under reset.
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_mem_valid", bus.mem_valid_o, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_count", count, 4'd0);
        check("rst_ld_hit", ld_hit, 1'b0);
        check("rst_req_ready", bus.req_ready_o, 1'b1);
        tick();

        // Lone store: ages AGE_MAX cycles, then issue latches on the next edge.
        set_req(1'b1, 64'h1000_0040, 64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b0, 1'b0);
        tick();
        idle();
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.mem_valid_o === 1'b1) break;
            tick();
            lat++;
        end
        check("age_latency", lat, AGE_MAX + 1);
        bus.mem_ready_i = 1'b1;
        tick();
        bus.mem_ready_i = 1'b0;
        #1;
        check("single_drained", empty, 1'b1);
        tick();

        // Two half-word stores to one word coalesce into a single full entry.
        set_req(1'b1, 64'h8000_0000, 64'h1111_2222_3333_4444, 8'h0F, 1'b0, 1'b0);
        tick();
        set_req(1'b1, 64'h8000_0004, 64'h5555_6666_7777_8888, 8'hF0, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        check("merge_count", count, 4'd1);
        wait_issue("merge");
        check("merge_be", bus.mem_be_o, 8'hFF);
        check("merge_data", bus.mem_data_o, 64'h5555_6666_3333_4444);
        check("merge_addr", bus.mem_addr_o, 64'h8000_0000);
        drain_all();

        // Full-word tagged store keeps its tag.
        set_req(1'b1, 64'h4000_0008, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 1'b1, 1'b0);
        tick();
        idle();
        wait_issue("tag_full");
        check("tag_full", bus.mem_tag_o, 1'b1);
        drain_all();

        // A partial merge into a tagged word clears the tag.
        set_req(1'b1, 64'h4000_0010, 64'h0102_0304_0506_0708, 8'hFF, 1'b1, 1'b0);
        tick();
        set_req(1'b1, 64'h4000_0013, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01, 1'b1, 1'b0);
        tick();
        idle();
        wait_issue("tag_part");
        check("tag_part", bus.mem_tag_o, 1'b0);
        check("tag_part_data", bus.mem_data_o, 64'h0102_0304_0506_07FF);
        drain_all();

        // Fill all entries with distinct words.
        for (int i = 0; i < DEPTH; i++) begin
            set_req(1'b1, 64'h2000_0000 + 64'(i * 8), 64'(i) * 64'h0101_0101_0101_0101,
                    8'hFF, 1'b0, 1'b0);
            tick();
        end
        idle();
        #1;
        check("fill_full", full, 1'b1);
        set_req(1'b1, 64'h2000_0100, 64'h0, 8'hFF, 1'b0, 1'b0);
        #1;
        check("full_new_word_ready", bus.req_ready_o, 1'b0);
        tick();
        set_req(1'b1, 64'h2000_003A, 64'h0000_0000_00EE_0000, 8'h04, 1'b0, 1'b0);
        #1;
        check("full_merge_ready", bus.req_ready_o, 1'b1);
        tick();
        idle();
        ld_addr = 64'h2000_0015;
        #1;
        check("full_merge_count", count, 4'd8);
        check("ld_hit_present", ld_hit, 1'b1);
        tick();
        ld_addr = 64'h2000_0100;
        #1;
        check("ld_hit_absent", ld_hit, 1'b0);
        tick();
        drain_all();

        // Non-cacheable store to the youngest word allocates a second entry.
        set_req(1'b1, 64'h5000_0020, 64'h1234_5678_9ABC_DEF0, 8'hFF, 1'b0, 1'b0);
        tick();
        set_req(1'b1, 64'h5000_0021, 64'h0000_0000_0000_5500, 8'h02, 1'b0, 1'b1);
        tick();
        idle();
        #1;
        check("nc_count", count, 4'd2);
        bus.mem_ready_i = 1'b1;
        hs = 0;
        for (int k = 0; k < 30; k++) begin
            if (empty === 1'b1) break;
            if (bus.mem_valid_o === 1'b1) hs++;
            tick();
        end
        bus.mem_ready_i = 1'b0;
        check("nc_drains", hs, 2);

        // Reset while draining drops everything on the next cycle.
        for (int i = 0; i < 5; i++) begin
            set_req(1'b1, 64'h6000_0000 + 64'(i * 8), 64'(i + 1), 8'hFF, 1'b0, 1'b0);
            tick();
        end
        idle();
        tick();
        check("pre_rst_valid", bus.mem_valid_o, 1'b1);
        check("pre_rst_count", count, 4'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_valid", bus.mem_valid_o, 1'b0);
        check("post_rst_empty", empty, 1'b1);
        tick();

        // Random traffic over a small word pool to exercise merges, full and flush.
        for (int k = 0; k < 400; k++) begin
            rst             = ($urandom_range(0, 99) == 0);
            flush           = ($urandom_range(0, 9) == 0);
            bus.mem_ready_i = ($urandom_range(0, 9) < 4);
            set_req(($urandom_range(0, 9) < 7),
                    64'h3000_0000 + 64'($urandom_range(0, 5) * 8) + 64'($urandom_range(0, 7)),
                    {$urandom, $urandom}, 8'($urandom), 1'($urandom),
                    ($urandom_range(0, 7) == 0));
            ld_addr = 64'h3000_0000 + 64'($urandom_range(0, 6) * 8);
            tick();
        end
        rst = 1'b0;
        drain_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
